// File: rtl/anomaly_filter_stream.sv
// anomaly_filter_stream
// Streaming pixel-pair anomaly filter with valid/ready flow control.
// Each accepted (orig, anom) pair is compared with a tolerance window. On a
// match the pixel is replaced by either BG_VALUE (mode 0) or the last clean
// pixel of the current line (mode 1). Otherwise the anomaly-map pixel passes.
// Frame/line markers travel with their pixel through a 2-stage pipeline.
//
// Ports:
//   clk, rst              clock (rising edge), async active-high reset
//   mode                  0 = replace with BG_VALUE, 1 = replace with last clean pixel
//   s_valid/s_ready       input handshake
//   s_orig, s_anom        original and anomaly-map pixel
//   s_sof, s_eol          first pixel of frame, last pixel of line
//   m_valid/m_ready       output handshake
//   m_pixel               filtered pixel
//   m_sof, m_eol          markers aligned with m_pixel
//   m_replaced            m_pixel is a replacement value
//   anomaly_count, frame_done   only when ANOMALY_COUNT_EN is defined
//
// Optional feature: define ANOMALY_COUNT_EN to add a per-frame saturating
// count of replaced pixels and a frame_done pulse.

module anomaly_filter_stream #(
    parameter int                PIX_W    = 8,
    parameter int                TOL      = 0,
    parameter logic [PIX_W-1:0]  BG_VALUE = '0,
    parameter int                CNT_W    = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [PIX_W-1:0] s_orig,
    input  logic [PIX_W-1:0] s_anom,
    input  logic             s_sof,
    input  logic             s_eol,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [PIX_W-1:0] m_pixel,
    output logic             m_sof,
    output logic             m_eol,
    output logic             m_replaced
`ifdef ANOMALY_COUNT_EN
    ,
    output logic [CNT_W-1:0] anomaly_count,
    output logic             frame_done
`endif
);

    localparam logic [PIX_W:0] TOL_V = (PIX_W+1)'(TOL);

    logic             adv;
    logic [PIX_W:0]   ext_orig;
    logic [PIX_W:0]   ext_anom;
    logic [PIX_W:0]   abs_diff;
    logic             in_match;

    logic             s1_valid;
    logic [PIX_W-1:0] s1_anom;
    logic             s1_sof;
    logic             s1_eol;
    logic             s1_mode;
    logic             s1_match;

    logic [PIX_W-1:0] last_clean;

    // Both stages move together whenever the output register is free or drained.
    assign adv     = !m_valid || m_ready;
    assign s_ready = adv;

    // Difference taken one bit wider than the pixel so underflow cannot wrap.
    always_comb begin
        ext_orig = {1'b0, s_orig};
        ext_anom = {1'b0, s_anom};
        abs_diff = (ext_orig >= ext_anom) ? (ext_orig - ext_anom) : (ext_anom - ext_orig);
        in_match = (abs_diff <= TOL_V);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_anom  <= '0;
            s1_sof   <= 1'b0;
            s1_eol   <= 1'b0;
            s1_mode  <= 1'b0;
            s1_match <= 1'b0;
        end else if (adv) begin
            s1_valid <= s_valid;
            if (s_valid) begin
                s1_anom  <= s_anom;
                s1_sof   <= s_sof;
                s1_eol   <= s_eol;
                s1_mode  <= mode;
                s1_match <= in_match;
            end
        end
    end

    // last_clean is advanced as each pixel is committed into the output
    // register. Pixels leave in order, so this is equivalent to updating on
    // departure while letting the very next pixel already see the new value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid    <= 1'b0;
            m_pixel    <= '0;
            m_sof      <= 1'b0;
            m_eol      <= 1'b0;
            m_replaced <= 1'b0;
            last_clean <= BG_VALUE;
        end else if (adv) begin
            m_valid <= s1_valid;
            if (s1_valid) begin
                m_sof      <= s1_sof;
                m_eol      <= s1_eol;
                m_replaced <= s1_match;
                if (s1_match) begin
                    m_pixel <= s1_mode ? last_clean : BG_VALUE;
                end else begin
                    m_pixel <= s1_anom;
                end
                // Line/frame boundaries win over a clean-pixel update.
                if (s1_sof || s1_eol) begin
                    last_clean <= BG_VALUE;
                end else if (!s1_match) begin
                    last_clean <= s1_anom;
                end
            end
        end
    end

`ifdef ANOMALY_COUNT_EN
    logic             load_out;
    logic [CNT_W-1:0] run_count;
    logic [CNT_W-1:0] frame_total;
    logic             seen_frame;

    assign load_out = adv && s1_valid;

    // During the frame_done cycle the finished frame's total is shown; the
    // running count has already restarted with the new sof pixel.
    assign anomaly_count = frame_done ? frame_total : run_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_count   <= '0;
            frame_total <= '0;
            seen_frame  <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (load_out) begin
                if (s1_sof) begin
                    frame_done  <= seen_frame;
                    frame_total <= run_count;
                    run_count   <= CNT_W'(s1_match);
                    seen_frame  <= 1'b1;
                end else if (s1_match && (run_count != '1)) begin
                    run_count <= run_count + 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_anomaly_filter_stream.sv
// tb_anomaly_filter_stream
// Directed bench for anomaly_filter_stream. Two instances share one input
// stream: u_exact (TOL=0) and u_tol (TOL=2). Each accepted pixel pushes its
// expected output into a per-instance queue; a monitor on the falling edge
// pops and compares on every output handshake and checks that outputs hold
// while stalled.

module tb_anomaly_filter_stream;

    typedef struct packed {
        logic [7:0] pix;
        logic       rep;
        logic       sof;
        logic       eol;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode;
    logic       s_valid;
    logic [7:0] s_orig;
    logic [7:0] s_anom;
    logic       s_sof;
    logic       s_eol;
    logic       m_ready;

    logic       s_ready_e, m_valid_e, m_sof_e, m_eol_e, m_replaced_e;
    logic [7:0] m_pixel_e;
    logic       s_ready_t, m_valid_t, m_sof_t, m_eol_t, m_replaced_t;
    logic [7:0] m_pixel_t;
`ifdef ANOMALY_COUNT_EN
    logic [1:0] anomaly_count_e, anomaly_count_t;
    logic       frame_done_e, frame_done_t;
    int         fd_n;
    logic [1:0] fd_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    exp_t q_e[$];
    exp_t q_t[$];
    logic [7:0] lc_e, lc_t;
    logic       toggle_en = 1'b0;

    logic        stall_prev = 1'b0;
    logic [11:0] hold_e, hold_t;

    always #5 clk = ~clk;

    anomaly_filter_stream #(.PIX_W(8), .TOL(0), .BG_VALUE(8'h00), .CNT_W(2)) u_exact (
        .clk(clk), .rst(rst), .mode(mode),
        .s_valid(s_valid), .s_ready(s_ready_e), .s_orig(s_orig), .s_anom(s_anom),
        .s_sof(s_sof), .s_eol(s_eol),
        .m_valid(m_valid_e), .m_ready(m_ready), .m_pixel(m_pixel_e),
        .m_sof(m_sof_e), .m_eol(m_eol_e), .m_replaced(m_replaced_e)
`ifdef ANOMALY_COUNT_EN
        , .anomaly_count(anomaly_count_e), .frame_done(frame_done_e)
`endif
    );

    anomaly_filter_stream #(.PIX_W(8), .TOL(2), .BG_VALUE(8'h00), .CNT_W(2)) u_tol (
        .clk(clk), .rst(rst), .mode(mode),
        .s_valid(s_valid), .s_ready(s_ready_t), .s_orig(s_orig), .s_anom(s_anom),
        .s_sof(s_sof), .s_eol(s_eol),
        .m_valid(m_valid_t), .m_ready(m_ready), .m_pixel(m_pixel_t),
        .m_sof(m_sof_t), .m_eol(m_eol_t), .m_replaced(m_replaced_t)
`ifdef ANOMALY_COUNT_EN
        , .anomaly_count(anomaly_count_t), .frame_done(frame_done_t)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    task automatic model(input logic [7:0] o, input logic [7:0] a, input logic sof,
                         input logic eol, input logic md, input int tol,
                         inout logic [7:0] lc, output exp_t e);
        int d;
        d = (o > a) ? (int'(o) - int'(a)) : (int'(a) - int'(o));
        e.sof = sof;
        e.eol = eol;
        if (d <= tol) begin
            e.rep = 1'b1;
            e.pix = md ? lc : 8'h00;
        end else begin
            e.rep = 1'b0;
            e.pix = a;
            lc    = a;
        end
        if (sof || eol) lc = 8'h00;
    endtask

    // Presents one pair from posedge+1 and returns at posedge+1 after acceptance.
    task automatic drive(input logic [7:0] o, input logic [7:0] a, input logic sof,
                         input logic eol, input logic md);
        int waited;
        waited  = 0;
        s_valid = 1'b1;
        s_orig  = o;
        s_anom  = a;
        s_sof   = sof;
        s_eol   = eol;
        mode    = md;
        forever begin
            @(negedge clk);
            if (s_ready_e) break;
            waited++;
            if (waited > 50) begin
                chk("accept_timeout", 32'd1, 32'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic send_exp(input logic [7:0] o, input logic [7:0] a, input logic sof,
                            input logic eol, input logic md,
                            input logic [7:0] pe, input logic re,
                            input logic [7:0] pt, input logic rt);
        exp_t dummy;
        drive(o, a, sof, eol, md);
        model(o, a, sof, eol, md, 0, lc_e, dummy);
        model(o, a, sof, eol, md, 2, lc_t, dummy);
        q_e.push_back('{pix: pe, rep: re, sof: sof, eol: eol});
        q_t.push_back('{pix: pt, rep: rt, sof: sof, eol: eol});
    endtask

    task automatic send_rnd(input logic [7:0] o, input logic [7:0] a, input logic sof,
                            input logic eol, input logic md);
        exp_t ee, et;
        drive(o, a, sof, eol, md);
        model(o, a, sof, eol, md, 0, lc_e, ee);
        model(o, a, sof, eol, md, 2, lc_t, et);
        q_e.push_back(ee);
        q_t.push_back(et);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q_e.size() != 0 || q_t.size() != 0) && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_left", 32'(q_e.size() + q_t.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t ex;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_e", 32'({m_valid_e, m_pixel_e, m_replaced_e, m_sof_e, m_eol_e}), 32'(hold_e));
                chk("hold_t", 32'({m_valid_t, m_pixel_t, m_replaced_t, m_sof_t, m_eol_t}), 32'(hold_t));
            end
            if (m_valid_e && !m_ready) chk("s_ready_stall", 32'(s_ready_e), 32'd0);
            if (m_valid_e && m_ready) begin
                if (q_e.size() == 0) chk("extra_out_e", 32'd1, 32'd0);
                else begin
                    ex = q_e.pop_front();
                    chk("out_e", 32'({m_pixel_e, m_replaced_e, m_sof_e, m_eol_e}), 32'(ex));
                end
            end
            if (m_valid_t && m_ready) begin
                if (q_t.size() == 0) chk("extra_out_t", 32'd1, 32'd0);
                else begin
                    ex = q_t.pop_front();
                    chk("out_t", 32'({m_pixel_t, m_replaced_t, m_sof_t, m_eol_t}), 32'(ex));
                end
            end
            stall_prev = m_valid_e && !m_ready;
            hold_e = {m_valid_e, m_pixel_e, m_replaced_e, m_sof_e, m_eol_e};
            hold_t = {m_valid_t, m_pixel_t, m_replaced_t, m_sof_t, m_eol_t};
        end
    end

`ifdef ANOMALY_COUNT_EN
    always @(negedge clk) begin
        if (!rst && frame_done_e) begin
            fd_n++;
            fd_cnt = anomaly_count_e;
        end
    end
`endif

    initial begin
        logic [7:0] o, a;
        int         d;
        rst = 1'b1; mode = 1'b0; s_valid = 1'b0; s_orig = '0; s_anom = '0;
        s_sof = 1'b0; s_eol = 1'b0; m_ready = 1'b1; lc_e = '0; lc_t = '0;
`ifdef ANOMALY_COUNT_EN
        fd_n = 0; fd_cnt = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_valid", 32'(m_valid_e), 32'd0);
        chk("rst_m_pixel", 32'(m_pixel_e), 32'd0);
        chk("rst_flags", 32'({m_sof_e, m_eol_e, m_replaced_e}), 32'd0);
        chk("rst_s_ready", 32'(s_ready_e), 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // exact match and 2-cycle latency
        send_exp(8'h40, 8'h40, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1);
        chk("lat_after_1", 32'(m_valid_e), 32'd0);
        @(posedge clk);
        #1;
        chk("lat_after_2", 32'(m_valid_e), 32'd1);
        chk("lat_pixel", 32'(m_pixel_e), 32'h00);
        chk("lat_replaced", 32'(m_replaced_e), 32'd1);
        send_exp(8'h40, 8'h41, 1'b0, 1'b1, 1'b0, 8'h41, 1'b0, 8'h00, 1'b1);
        drain();

        // tolerance window, underflow must not wrap
        send_exp(8'h80, 8'h82, 1'b0, 1'b0, 1'b0, 8'h82, 1'b0, 8'h00, 1'b1);
        send_exp(8'h80, 8'h83, 1'b0, 1'b0, 1'b0, 8'h83, 1'b0, 8'h83, 1'b0);
        send_exp(8'h05, 8'h03, 1'b0, 1'b1, 1'b0, 8'h03, 1'b0, 8'h00, 1'b1);
        drain();

        // hold mode: last clean pixel, line reset after eol
        send_exp(8'd1, 8'd9, 1'b0, 1'b0, 1'b1, 8'd9, 1'b0, 8'd9, 1'b0);
        send_exp(8'd5, 8'd5, 1'b0, 1'b0, 1'b1, 8'd9, 1'b1, 8'd9, 1'b1);
        send_exp(8'd7, 8'd7, 1'b0, 1'b0, 1'b1, 8'd9, 1'b1, 8'd9, 1'b1);
        send_exp(8'd2, 8'd8, 1'b0, 1'b1, 1'b1, 8'd8, 1'b0, 8'd8, 1'b0);
        send_exp(8'd3, 8'd3, 1'b0, 1'b1, 1'b1, 8'd0, 1'b1, 8'd0, 1'b1);
        drain();

        // per-pixel mode change mid-line
        send_exp(8'h10, 8'h20, 1'b0, 1'b0, 1'b1, 8'h20, 1'b0, 8'h20, 1'b0);
        send_exp(8'h30, 8'h30, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1);
        send_exp(8'h31, 8'h31, 1'b0, 1'b1, 1'b1, 8'h20, 1'b1, 8'h20, 1'b1);
        drain();

        // reset mid-frame with two pixels in flight
        send_exp(8'h10, 8'h50, 1'b0, 1'b0, 1'b1, 8'h50, 1'b0, 8'h50, 1'b0);
        drain();
        m_ready = 1'b0;
        drive(8'h11, 8'h11, 1'b0, 1'b0, 1'b1);
        drive(8'h12, 8'h12, 1'b0, 1'b0, 1'b1);
        chk("inflight_valid", 32'(m_valid_e), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_m_valid", 32'(m_valid_e), 32'd0);
        chk("midrst_m_pixel", 32'(m_pixel_e), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_ready = 1'b1;
        lc_e = '0;
        lc_t = '0;
        @(posedge clk);
        #1;
        chk("post_rst_idle", 32'(m_valid_e), 32'd0);
        send_exp(8'h22, 8'h22, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 8'h00, 1'b1);
        send_exp(8'h23, 8'h40, 1'b0, 1'b0, 1'b1, 8'h40, 1'b0, 8'h40, 1'b0);
        send_exp(8'h24, 8'h24, 1'b0, 1'b1, 1'b1, 8'h40, 1'b1, 8'h40, 1'b1);
        drain();

        // backpressure: m_ready toggling, random gaps, random data
        toggle_en = 1'b1;
        fork
            while (toggle_en) begin
                @(posedge clk);
                #2;
                m_ready = ~m_ready;
            end
        join_none
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            o = 8'($urandom_range(0, 255));
            d = int'(o) + int'($urandom_range(0, 6)) - 3;
            if (d < 0) d = 0;
            if (d > 255) d = 255;
            a = 8'(d);
            send_rnd(o, a, (i == 0), (i == 3 || i == 7), 1'($urandom_range(0, 1)));
        end
        toggle_en = 1'b0;
        @(posedge clk);
        #3;
        m_ready = 1'b1;
        drain();

`ifdef ANOMALY_COUNT_EN
        // frame A: 3 replaced in exact instance
        send_exp(8'd1, 8'd1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 8'd0, 1'b1);
        send_exp(8'd2, 8'd3, 1'b0, 1'b0, 1'b0, 8'd3, 1'b0, 8'd0, 1'b1);
        send_exp(8'd4, 8'd4, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 8'd0, 1'b1);
        send_exp(8'd5, 8'd5, 1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 8'd0, 1'b1);
        drain();
        fd_n = 0;
        // frame B: 5 replaced, saturating the 2-bit counter
        send_exp(8'd7, 8'd8, 1'b1, 1'b0, 1'b0, 8'd8, 1'b0, 8'd0, 1'b1);
        drain();
        chk("fd_pulses_a", 32'(fd_n), 32'd1);
        chk("fd_count_a", 32'(fd_cnt), 32'd3);
        for (int i = 0; i < 5; i++)
            send_exp(8'(i), 8'(i), 1'b0, (i == 4), 1'b0, 8'd0, 1'b1, 8'd0, 1'b1);
        drain();
        fd_n = 0;
        send_exp(8'd6, 8'd7, 1'b1, 1'b0, 1'b0, 8'd7, 1'b0, 8'd0, 1'b1);
        drain();
        chk("fd_pulses_b", 32'(fd_n), 32'd1);
        chk("fd_count_sat", 32'(fd_cnt), 32'd3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
